// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. Bytes are released one at a
// time through a one-cycle enable pulse, only after the previous frame has fully drained.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   s_valid_i,
    input  logic [7:0]             s_data_i,
    output logic                   s_ready_o,
    output logic                   tx_e_o,
    output logic [7:0]             tx_d_o,
    input  logic                   tx_busy_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop;

    // Flags depend only on registered pointers, never on s_valid_i.
    assign count_o   = wr_ptr - rd_ptr;
    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == (AW+1)'(DEPTH));
    assign s_ready_o = !full_o;
    assign push      = s_valid_i && s_ready_o;

    assign tx_e_o    = (state == SEND);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_data_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Held from pop to next pop, so the transmitter sees a stable byte for the whole frame.
    always_ff @(posedge clk) begin
        if (!resetn)
            tx_d_o <= 8'h00;
        else if (pop)
            tx_d_o <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ACK waits for busy to rise so a slow-to-respond transmitter cannot get a second pulse.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_o && !tx_busy_i) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:  state_nxt = ACK;
            ACK:   if (tx_busy_i) state_nxt = DRAIN;
            DRAIN: if (!tx_busy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule
